// File: rtl/matmul_engine.sv
// Sequencing/MAC stage for C = A x B on square NxN row-major matrices.
// Reads A/B through registered-address BRAM ports and writes each C element once.
module matmul_engine #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_dout,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic [ADDR_WIDTH-1:0] c_wr_addr,
    output logic                  c_wr_en,
    output logic [DATA_WIDTH-1:0] c_din
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         i, j, k;
    logic [CW-1:0]         i_nxt, j_nxt, k_nxt;
    logic                  last_i, last_j, last_k;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] prod;

    // N is a power of two, so row*N+col is just the two indices concatenated.
    function automatic logic [ADDR_WIDTH-1:0] idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return ADDR_WIDTH'({r, c});
    endfunction

    assign i_nxt  = i + CW'(1);
    assign j_nxt  = j + CW'(1);
    assign k_nxt  = k + CW'(1);
    assign last_i = &i;
    assign last_j = &j;
    assign last_k = &k;

    // Product and sum wrap modulo 2**DATA_WIDTH; the high bits are dropped by design.
    assign prod  = a_dout * b_dout;
    assign c_din = (state == WRITE) ? acc + prod : '0;

    // NOTE: every register here is updated with non-blocking assignments so all
    // next-state terms see the values from before the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
            c_wr_addr <= '0;
            c_wr_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= MAC;
                        busy      <= 1'b1;
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        acc       <= '0;
                        a_rd_addr <= '0;
                        b_rd_addr <= '0;
                    end
                end

                MAC: begin
                    // Data on the ports belongs to the address issued for k-1.
                    if (k != '0) acc <= acc + prod;
                    if (last_k) begin
                        state     <= WRITE;
                        a_rd_addr <= '0;
                        b_rd_addr <= '0;
                        c_wr_en   <= 1'b1;
                        c_wr_addr <= idx(i, j);
                    end else begin
                        k         <= k_nxt;
                        a_rd_addr <= idx(i, k_nxt);
                        b_rd_addr <= idx(k_nxt, j);
                    end
                end

                WRITE: begin
                    c_wr_en   <= 1'b0;
                    c_wr_addr <= '0;
                    acc       <= '0;
                    k         <= '0;
                    j         <= j_nxt;
                    if (last_j) i <= i_nxt;
                    if (last_i && last_j) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= MAC;
                        a_rd_addr <= idx(last_j ? i_nxt : i, '0);
                        b_rd_addr <= idx('0, j_nxt);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: a reference matrix product fills the expected
// write queue, a negedge monitor pops and compares every C write the DUT makes.
module tb_matmul_engine;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int NN  = N * N;
    localparam int JOB = NN * (N + 1);

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_rd_addr;
    logic [DW-1:0] a_dout;
    logic [AW-1:0] b_rd_addr;
    logic [DW-1:0] b_dout;
    logic [AW-1:0] c_wr_addr;
    logic          c_wr_en;
    logic [DW-1:0] c_din;

    matmul_engine #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .a_rd_addr (a_rd_addr),
        .a_dout    (a_dout),
        .b_rd_addr (b_rd_addr),
        .b_dout    (b_dout),
        .c_wr_addr (c_wr_addr),
        .c_wr_en   (c_wr_en),
        .c_din     (c_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Operand BRAMs: address registered, data one cycle later.
    logic [DW-1:0] mem_a [NN];
    logic [DW-1:0] mem_b [NN];
    always @(posedge clock) begin
        a_dout <= mem_a[a_rd_addr];
        b_dout <= mem_b[b_rd_addr];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors;
    int  miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain row-by-column dot product, reduced modulo 256.
    task automatic push_expected();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int  s;
                wr_t e;
                s = 0;
                for (int kk = 0; kk < N; kk++)
                    s += int'(mem_a[r*N+kk]) * int'(mem_b[kk*N+c]);
                e.addr = AW'(r * N + c);
                e.data = DW'(s % 256);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clock) begin
        if (c_wr_en === 1'b1) begin
            wr_t e;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected at %0t",
                         c_wr_addr, c_din, $time);
            end else begin
                e = exp_q.pop_front();
                check("c_wr_addr", 32'(c_wr_addr), 32'(e.addr));
                check("c_din", 32'(c_din), 32'(e.data));
            end
        end
    end

    task automatic load(input int mode);
        for (int n = 0; n < NN; n++) begin
            case (mode)
                0: begin mem_a[n] = ((n / N) == (n % N)) ? 8'd1 : 8'd0; mem_b[n] = DW'(n + 1); end
                1: begin mem_a[n] = 8'hFF; mem_b[n] = 8'h02; end
                2: begin mem_a[n] = DW'($urandom_range(255, 200)); mem_b[n] = DW'($urandom_range(255, 200)); end
                default: begin mem_a[n] = DW'($urandom); mem_b[n] = DW'($urandom); end
            endcase
        end
    endtask

    // One job from an IDLE engine; optional stray start pulses at cycle 5 and in DONE.
    task automatic run_job(input bit stray);
        int cyc;
        push_expected();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (stray && cyc == 5) start = 1'b1;
            if (stray && cyc == 6) start = 1'b0;
            if (cyc <= JOB) begin
                check("busy_in_job", 32'(busy), 32'd1);
                check("wr_cadence", 32'(c_wr_en), 32'((cyc % (N + 1)) == 0));
            end
            if (done === 1'b1 || cyc >= JOB + 20) break;
        end
        check("done_latency", 32'(cyc), 32'(JOB + 1));
        check("busy_in_done", 32'(busy), 32'd1);
        if (stray) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("done_single_pulse", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        @(negedge clock);
        check("no_restart", 32'(busy), 32'd0);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_continuous();
        int cyc;
        int first;
        push_expected();
        push_expected();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        cyc   = 0;
        first = -1;
        forever begin
            @(negedge clock);
            cyc++;
            if (done === 1'b1) begin
                if (first < 0) first = cyc;
                else break;
            end
            if (cyc >= 3 * JOB) break;
        end
        start = 1'b0;
        check("first_done", 32'(first), 32'(JOB + 1));
        check("done_gap", 32'(cyc - first), 32'(JOB + 2));
        repeat (3) @(negedge clock);
        check("cont_idle", 32'(busy), 32'd0);
        check("cont_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_reset_mid();
        push_expected();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2 * (N + 1)) @(negedge clock);
        check("second_write_active", 32'(c_wr_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_ctrl", 32'({busy, done, c_wr_en}), 32'd0);
        check("rst_addr", 32'({a_rd_addr, b_rd_addr, c_wr_addr}), 32'd0);
        check("rst_c_din", 32'(c_din), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check("idle_after_reset", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        reset_n     = 1'b0;
        load(0);
        #1;
        check("reset_ctrl", 32'({busy, done, c_wr_en}), 32'd0);
        check("reset_addr", 32'({a_rd_addr, b_rd_addr, c_wr_addr}), 32'd0);
        check("reset_c_din", 32'(c_din), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);

        run_job(1'b0);                 // identity x (n+1)
        load(1); run_job(1'b0);        // wrap: 0xFF x 0x02
        load(2); run_job(1'b0);        // large operands, heavy wrap
        load(3); run_job(1'b1);        // random, stray starts ignored
        load(3); run_reset_mid();
        run_job(1'b0);                 // same operands recomputed after reset
        load(3); run_continuous();
        for (int t = 0; t < 3; t++) begin
            load(3);
            run_job(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
